// File: rtl/capture_sched_pkg.sv
// Shared types and helpers for the capture scheduler: FSM state encoding, beat geometry and the
// configuration sanity check applied when a run is armed.
package capture_sched_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StRun,
    StRelease,
    StNext,
    StError
  } sched_state_e;

  localparam int unsigned BEAT_BYTES = 64;
  localparam int unsigned BEAT_SHIFT = 6;

  // Arguments are zero-extended to 64 bits so the check is independent of ADDR_WIDTH.
  function automatic logic cfg_bad(logic [63:0] base, logic [63:0] ring, logic [31:0] size,
                                   logic [63:0] cap_bytes);
    return (size == '0) || (cap_bytes > ring) || (base[5:0] != '0) || (ring[5:0] != '0);
  endfunction

endpackage

// File: rtl/ring_addr_gen.sv
// Ring offset and wrap counter for the capture scheduler; offers the offset the next capture
// will use so the top can register the start address on the same edge the offset advances.
module ring_addr_gen #(
  parameter int unsigned ADDR_WIDTH = 34,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  advance_i,
  input  logic [ADDR_WIDTH-1:0] cap_bytes_i,
  input  logic [ADDR_WIDTH-1:0] ring_bytes_i,
  output logic [ADDR_WIDTH-1:0] next_offset_o,
  output logic [CNT_WIDTH-1:0]  wrap_count_o
);

  logic [ADDR_WIDTH-1:0] offset_q, offset_d;
  logic [CNT_WIDTH-1:0]  wrap_q, wrap_d;
  logic [ADDR_WIDTH:0]   nxt, nxt_end;
  logic                  wrap;

  // One guard bit keeps offset+2*cap_bytes from overflowing before the compare.
  always_comb begin
    nxt           = {1'b0, offset_q} + {1'b0, cap_bytes_i};
    nxt_end       = nxt + {1'b0, cap_bytes_i};
    wrap          = nxt_end > {1'b0, ring_bytes_i};
    next_offset_o = wrap ? '0 : nxt[ADDR_WIDTH-1:0];
  end

  always_comb begin
    offset_d = offset_q;
    wrap_d   = wrap_q;
    if (clear_i) begin
      offset_d = '0;
      wrap_d   = '0;
    end else if (advance_i) begin
      offset_d = next_offset_o;
      if (wrap && (wrap_q != '1)) begin
        wrap_d = wrap_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      offset_q <= '0;
      wrap_q   <= '0;
    end else begin
      offset_q <= offset_d;
      wrap_q   <= wrap_d;
    end
  end

  assign wrap_count_o = wrap_q;

endmodule

// File: rtl/capture_scheduler.sv
// Sequences a capture engine through back-to-back captures into a circular DDR region.
// Optional RUN watchdog enabled by defining CAPTURE_SCHED_TIMEOUT_EN.
module capture_scheduler
  import capture_sched_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 34,
  parameter int unsigned CNT_WIDTH      = 16,
  parameter int unsigned SETUP_CYCLES   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 2**24
) (
  input  logic                  clk_stream,
  input  logic                  reset_stream,
  input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic [ADDR_WIDTH-1:0] cfg_ring_bytes,
  input  logic [31:0]           cfg_capture_size,
  input  logic [CNT_WIDTH-1:0]  cfg_num_captures,
  input  logic                  cfg_arm,
  input  logic                  cfg_abort,
  output logic                  cap_start,
  output logic [ADDR_WIDTH-1:0] cap_start_addr,
  output logic [31:0]           cap_size,
  input  logic                  cap_done,
  output logic                  sched_busy,
  output logic                  sched_done,
  output logic                  sched_error,
  output logic [CNT_WIDTH-1:0]  capture_count,
  output logic [CNT_WIDTH-1:0]  wrap_count,
  output logic                  capture_irq
);

  sched_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d, ring_q, ring_d, cap_bytes_q, cap_bytes_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, arm_cap_bytes, next_offset;
  logic [31:0]           size_q, size_d;
  logic [CNT_WIDTH-1:0]  num_q, num_d, count_q, count_d;
  logic [7:0]            setup_cnt_q, setup_cnt_d;
  logic                  aborted_q, aborted_d, start_q, start_d, done_q, done_d;
  logic                  error_q, error_d, irq_q, irq_d, busy_q;
  logic                  ring_clear, ring_advance, timeout;

  assign arm_cap_bytes = ADDR_WIDTH'(cfg_capture_size) << BEAT_SHIFT;

`ifdef CAPTURE_SCHED_TIMEOUT_EN
  logic [31:0] run_cnt_q;

  always_ff @(posedge clk_stream) begin
    if (reset_stream || (state_q != StRun)) begin
      run_cnt_q <= '0;
    end else begin
      run_cnt_q <= run_cnt_q + 1'b1;
    end
  end

  assign timeout = (state_q == StRun) && !cap_done && (run_cnt_q == 32'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout            = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    ring_d       = ring_q;
    cap_bytes_d  = cap_bytes_q;
    addr_d       = addr_q;
    size_d       = size_q;
    num_d        = num_q;
    count_d      = count_q;
    setup_cnt_d  = setup_cnt_q;
    aborted_d    = aborted_q;
    start_d      = start_q;
    done_d       = done_q;
    error_d      = error_q;
    irq_d        = 1'b0;
    ring_clear   = 1'b0;
    ring_advance = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cfg_arm && !cfg_abort) begin
          base_d      = cfg_base_addr;
          ring_d      = cfg_ring_bytes;
          size_d      = cfg_capture_size;
          num_d       = cfg_num_captures;
          cap_bytes_d = arm_cap_bytes;
          count_d     = '0;
          done_d      = 1'b0;
          ring_clear  = 1'b1;
          if (cfg_bad(64'(cfg_base_addr), 64'(cfg_ring_bytes), cfg_capture_size,
                      64'(arm_cap_bytes))) begin
            state_d = StError;
            error_d = 1'b1;
          end else begin
            state_d     = StSetup;
            addr_d      = cfg_base_addr;
            setup_cnt_d = '0;
          end
        end
      end
      StSetup: begin
        if (cfg_abort) begin
          state_d = StIdle;
        end else if (setup_cnt_q == 8'(SETUP_CYCLES - 1)) begin
          state_d = StRun;
          start_d = 1'b1;
        end else begin
          setup_cnt_d = setup_cnt_q + 1'b1;
        end
      end
      StRun: begin
        // Abort outranks a coincident done: the capture is discarded.
        if (cfg_abort || cap_done) begin
          state_d   = StRelease;
          start_d   = 1'b0;
          aborted_d = cfg_abort;
        end else if (timeout) begin
          state_d = StError;
          start_d = 1'b0;
          error_d = 1'b1;
        end
      end
      StRelease: begin
        if (cfg_abort) begin
          aborted_d = 1'b1;
        end
        if (!cap_done) begin
          if (aborted_q || cfg_abort) begin
            state_d = StIdle;
          end else begin
            state_d = StNext;
            irq_d   = 1'b1;
            count_d = count_q + 1'b1;
          end
        end
      end
      StNext: begin
        if (cfg_abort) begin
          state_d = StIdle;
        end else begin
          ring_advance = 1'b1;
          if ((num_q != '0) && (count_q == num_q)) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            state_d     = StSetup;
            addr_d      = base_q + next_offset;
            setup_cnt_d = '0;
          end
        end
      end
      StError: begin
        if (cfg_abort) begin
          state_d = StIdle;
          error_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_stream) begin
    if (reset_stream) begin
      state_q     <= StIdle;
      base_q      <= '0;
      ring_q      <= '0;
      cap_bytes_q <= '0;
      addr_q      <= '0;
      size_q      <= '0;
      num_q       <= '0;
      count_q     <= '0;
      setup_cnt_q <= '0;
      aborted_q   <= 1'b0;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      irq_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      ring_q      <= ring_d;
      cap_bytes_q <= cap_bytes_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      num_q       <= num_d;
      count_q     <= count_d;
      setup_cnt_q <= setup_cnt_d;
      aborted_q   <= aborted_d;
      start_q     <= start_d;
      done_q      <= done_d;
      error_q     <= error_d;
      irq_q       <= irq_d;
      busy_q      <= (state_d != StIdle) && (state_d != StError);
    end
  end

  ring_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_ring_addr_gen (
    .clk_i        (clk_stream),
    .rst_i        (reset_stream),
    .clear_i      (ring_clear),
    .advance_i    (ring_advance),
    .cap_bytes_i  (cap_bytes_q),
    .ring_bytes_i (ring_q),
    .next_offset_o(next_offset),
    .wrap_count_o (wrap_count)
  );

  assign cap_start      = start_q;
  assign cap_start_addr = addr_q;
  assign cap_size       = size_q;
  assign sched_busy     = busy_q;
  assign sched_done     = done_q;
  assign sched_error    = error_q;
  assign capture_count  = count_q;
  assign capture_irq    = irq_q;

endmodule
